// File: rtl/counter_array_pkg.sv
// Shared encodings for the counter_array timer block: CTRL field positions
// and the counting modes a channel can run in.
package counter_array_pkg;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;
    localparam logic [1:0] MODE_SQUARE  = 2'b10;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IRQEN    = 3;
    localparam int CTRL_CLRPEND  = 4;

    typedef struct packed {
        logic       en;
        logic [1:0] mode;
        logic       irq_en;
    } ctrl_t;

endpackage

// File: rtl/counter_chan.sv
// One timer channel: tick synchroniser and edge detect, down-counter with
// one-shot / auto-reload / square behaviour, terminal output and pending flag.
module counter_chan
    import counter_array_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tick_i,
    input  logic             load_we_i,
    input  logic             ctrl_we_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] count_o,
    output logic             out_o,
    output logic             pend_o,
    output logic             irq_en_o
);

    // [0],[1] synchronise the asynchronous tick, [2] holds the previous level.
    logic [2:0]       sync_q;
    logic             tick_evt;
    logic [WIDTH-1:0] load_q, load_d;
    logic [WIDTH-1:0] count_q, count_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             out_q, out_d;
    logic             pulse_q, pulse_d;
    logic             pend_q, pend_d;

    assign tick_evt = sync_q[1] & ~sync_q[2];

    always_comb begin
        load_d  = load_q;
        count_d = count_q;
        ctrl_d  = ctrl_q;
        out_d   = out_q;
        pulse_d = 1'b0;
        pend_d  = pend_q;

        // An auto-reload terminal drives out for a single cycle only.
        if (pulse_q) begin
            out_d = 1'b0;
        end

        if (ctrl_we_i) begin
            ctrl_d.en     = wr_data_i[CTRL_EN];
            ctrl_d.mode   = wr_data_i[CTRL_MODE_LSB +: 2];
            ctrl_d.irq_en = wr_data_i[CTRL_IRQEN];
            if (wr_data_i[CTRL_CLRPEND]) begin
                pend_d = 1'b0;
            end
        end

        if (load_we_i) begin
            load_d  = wr_data_i;
            count_d = wr_data_i;
            out_d   = 1'b0;
        end else if (tick_evt && ctrl_q.en && (count_q != '0)) begin
            if (count_q != WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                pend_d = 1'b1;
                case (ctrl_q.mode)
                    MODE_RELOAD: begin
                        count_d = load_q;
                        out_d   = 1'b1;
                        pulse_d = 1'b1;
                    end
                    MODE_SQUARE: begin
                        count_d = load_q;
                        out_d   = ~out_q;
                    end
                    default: begin
                        count_d = '0;
                        out_d   = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            load_q  <= '0;
            count_q <= '0;
            ctrl_q  <= '0;
            out_q   <= 1'b0;
            pulse_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], tick_i};
            load_q  <= load_d;
            count_q <= count_d;
            ctrl_q  <= ctrl_d;
            out_q   <= out_d;
            pulse_q <= pulse_d;
            pend_q  <= pend_d;
        end
    end

    assign count_o  = count_q;
    assign out_o    = out_q;
    assign pend_o   = pend_q;
    assign irq_en_o = ctrl_q.irq_en;

endmodule

// File: rtl/counter_array.sv
// N-channel timer array: write decode to the channels, registered count
// read port and the combined interrupt.
module counter_array
    import counter_array_pkg::*;
#(
    parameter int NCH    = 3,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = $clog2(NCH) + 1
) (
    input  logic                                   clk,
    input  logic                                   RSTN,
    input  logic [NCH-1:0]                         tick_in,
    input  logic                                   wr_en,
    input  logic [ADDR_W-1:0]                      wr_addr,
    input  logic [WIDTH-1:0]                       wr_data,
    input  logic [(ADDR_W > 1 ? ADDR_W-2 : 0):0]   rd_ch,
    output logic [WIDTH-1:0]                       rd_data,
    output logic [NCH-1:0]                         ch_out,
    output logic [NCH-1:0]                         pending,
    output logic                                   irq
);

    localparam int RD_W = (ADDR_W > 1) ? ADDR_W - 1 : 1;

    logic [WIDTH-1:0]  count_w [NCH];
    logic [NCH-1:0]    out_w;
    logic [NCH-1:0]    pend_w;
    logic [NCH-1:0]    irq_en_w;
    logic [ADDR_W-1:0] wr_ch_w;
    logic [WIDTH-1:0]  rd_data_q, rd_data_d;
    logic              irq_q, irq_d;

    // Channel indices at or above NCH match no instance, so those writes vanish.
    assign wr_ch_w = wr_addr >> 1;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        counter_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk_i     (clk),
            .rst_ni    (RSTN),
            .tick_i    (tick_in[i]),
            .load_we_i (wr_en && !wr_addr[0] && (wr_ch_w == ADDR_W'(i))),
            .ctrl_we_i (wr_en &&  wr_addr[0] && (wr_ch_w == ADDR_W'(i))),
            .wr_data_i (wr_data),
            .count_o   (count_w[i]),
            .out_o     (out_w[i]),
            .pend_o    (pend_w[i]),
            .irq_en_o  (irq_en_w[i])
        );
    end

    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_ch == RD_W'(i)) begin
                rd_data_d = count_w[i];
            end
        end
        irq_d = |(pend_w & irq_en_w);
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            rd_data_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            irq_q     <= irq_d;
        end
    end

    assign rd_data = rd_data_q;
    assign ch_out  = out_w;
    assign pending = pend_w;
    assign irq     = irq_q;

endmodule

// File: tb/tb_counter_array.sv
// Bench for counter_array: a 3-channel 8-bit instance checked against a
// behavioural channel model, plus an 8-channel 16-bit instance.
module tb_counter_array;

    localparam int NCH = 3;
    localparam int W   = 8;

    logic           clk = 1'b0;
    logic           RSTN;
    logic [NCH-1:0] tick_in;
    logic           wr_en;
    logic [2:0]     wr_addr;
    logic [W-1:0]   wr_data;
    logic [1:0]     rd_ch;
    logic [W-1:0]   rd_data;
    logic [NCH-1:0] ch_out;
    logic [NCH-1:0] pending;
    logic           irq;

    logic [7:0]     w_tick;
    logic           w_wr_en;
    logic [3:0]     w_wr_addr;
    logic [15:0]    w_wr_data;
    logic [2:0]     w_rd_ch;
    logic [15:0]    w_rd_data;
    logic [7:0]     w_ch_out;
    logic [7:0]     w_pending;
    logic           w_irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    counter_array #(.NCH(NCH), .WIDTH(W)) dut (
        .clk(clk), .RSTN(RSTN), .tick_in(tick_in), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_ch(rd_ch), .rd_data(rd_data), .ch_out(ch_out),
        .pending(pending), .irq(irq)
    );

    counter_array #(.NCH(8), .WIDTH(16)) dut_wide (
        .clk(clk), .RSTN(RSTN), .tick_in(w_tick), .wr_en(w_wr_en), .wr_addr(w_wr_addr),
        .wr_data(w_wr_data), .rd_ch(w_rd_ch), .rd_data(w_rd_data), .ch_out(w_ch_out),
        .pending(w_pending), .irq(w_irq)
    );

    // Behavioural model of the 3-channel instance.
    logic [W-1:0] m_load [NCH];
    logic [W-1:0] m_count[NCH];
    logic [1:0]   m_mode [NCH];
    logic         m_en   [NCH];
    logic         m_irqen[NCH];
    logic         m_out  [NCH];
    logic         m_pend [NCH];
    logic         m_pulse;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_load[i] = '0; m_count[i] = '0; m_mode[i] = '0; m_en[i] = 1'b0;
            m_irqen[i] = 1'b0; m_out[i] = 1'b0; m_pend[i] = 1'b0;
        end
        m_pulse = 1'b0;
    endtask

    task automatic model_tick(input int ch);
        m_pulse = 1'b0;
        if (m_en[ch] && m_count[ch] != 0) begin
            if (m_count[ch] > 1) begin
                m_count[ch] = m_count[ch] - 1'b1;
            end else begin
                m_pend[ch] = 1'b1;
                if (m_mode[ch] == 2'd1) begin
                    m_count[ch] = m_load[ch]; m_out[ch] = 1'b0; m_pulse = 1'b1;
                end else if (m_mode[ch] == 2'd2) begin
                    m_count[ch] = m_load[ch]; m_out[ch] = ~m_out[ch];
                end else begin
                    m_count[ch] = '0; m_out[ch] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_write(input int ch, input bit is_ctrl, input logic [W-1:0] d);
        if (ch < NCH) begin
            if (is_ctrl) begin
                m_en[ch] = d[0]; m_mode[ch] = d[2:1]; m_irqen[ch] = d[3];
                if (d[4]) m_pend[ch] = 1'b0;
            end else begin
                m_load[ch] = d; m_count[ch] = d; m_out[ch] = 1'b0;
            end
        end
    endtask

    function automatic logic exp_irq();
        logic r = 1'b0;
        for (int i = 0; i < NCH; i++) r = r | (m_pend[i] & m_irqen[i]);
        return r;
    endfunction

    function automatic logic [NCH-1:0] exp_pend();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_out();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_out[i];
        return v;
    endfunction

    // Drivers
    task automatic wr(input int ch, input bit is_ctrl, input logic [W-1:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = {ch[1:0], is_ctrl}; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        model_write(ch, is_ctrl, d);
        @(negedge clk);
    endtask

    task automatic do_tick(input int ch, output logic evt_out, output logic evt_irq,
                           output logic post_out, output logic post_irq);
        @(negedge clk);
        tick_in[ch] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_tick(ch);
        evt_out = ch_out[ch];
        evt_irq = irq;
        @(posedge clk);
        #1;
        post_out = ch_out[ch];
        post_irq = irq;
        @(negedge clk);
        tick_in[ch] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic read_count(input int ch, output logic [W-1:0] v);
        @(negedge clk);
        rd_ch = ch[1:0];
        @(posedge clk);
        #1;
        v = rd_data;
    endtask

    // Tests
    task automatic test_reset();
        RSTN = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            tick_in = 3'($urandom); wr_en = 1'($urandom); wr_addr = 3'($urandom);
            wr_data = 8'($urandom); rd_ch = 2'($urandom);
            w_tick = 8'($urandom); w_wr_en = 1'($urandom); w_wr_addr = 4'($urandom);
            w_wr_data = 16'($urandom); w_rd_ch = 3'($urandom);
            @(posedge clk); #1;
            n_tests++;
            if ({rd_data, ch_out, pending, irq} !== '0 || {w_rd_data, w_ch_out, w_pending, w_irq} !== '0) begin
                n_fail++;
                $display("FAIL reset_hold: got %h/%h expected 0", {rd_data, ch_out, pending, irq},
                         {w_rd_data, w_ch_out, w_pending, w_irq});
            end
        end
        @(negedge clk);
        tick_in = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_ch = '0;
        w_tick = '0; w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0; w_rd_ch = '0;
        @(negedge clk);
        RSTN = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({rd_data, ch_out, pending, irq} !== '0 || {w_rd_data, w_ch_out, w_pending, w_irq} !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got %h/%h expected 0", {rd_data, ch_out, pending, irq},
                     {w_rd_data, w_ch_out, w_pending, w_irq});
        end
    endtask

    task automatic test_oneshot();
        logic eo, ei, po, pi;
        logic [W-1:0] v;
        wr(0, 0, 8'd3);
        wr(0, 1, 8'h01);
        for (int k = 0; k < 5; k++) begin
            do_tick(0, eo, ei, po, pi);
            read_count(0, v);
            n_tests++;
            if (v !== m_count[0]) begin
                n_fail++; $display("FAIL oneshot_count tick%0d: got %0d expected %0d", k, v, m_count[0]);
            end
            n_tests++;
            if (eo !== m_out[0] || po !== m_out[0]) begin
                n_fail++; $display("FAIL oneshot_out tick%0d: got %b/%b expected %b", k, eo, po, m_out[0]);
            end
            n_tests++;
            if (pending !== exp_pend()) begin
                n_fail++; $display("FAIL oneshot_pend tick%0d: got %b expected %b", k, pending, exp_pend());
            end
        end
    endtask

    task automatic test_reload();
        logic eo, ei, po, pi, ib;
        logic [W-1:0] v;
        int pulses = 0;
        wr(1, 0, 8'd2);
        wr(1, 1, 8'h0B);
        for (int k = 0; k < 8; k++) begin
            if (k == 6) begin
                wr(1, 1, 8'h1B);
                n_tests++;
                if (pending[1] !== 1'b0 || irq !== exp_irq()) begin
                    n_fail++; $display("FAIL reload_clr: got pend=%b irq=%b expected 0/%b", pending[1], irq, exp_irq());
                end
            end
            ib = exp_irq();
            do_tick(1, eo, ei, po, pi);
            if (eo) pulses++;
            n_tests++;
            if (eo !== (m_pulse | m_out[1]) || po !== m_out[1]) begin
                n_fail++; $display("FAIL reload_out tick%0d: got %b/%b expected %b/%b", k, eo, po, m_pulse | m_out[1], m_out[1]);
            end
            n_tests++;
            if (ei !== ib || pi !== exp_irq()) begin
                n_fail++; $display("FAIL reload_irq tick%0d: got %b/%b expected %b/%b", k, ei, pi, ib, exp_irq());
            end
            read_count(1, v);
            n_tests++;
            if (v !== m_count[1] || pending !== exp_pend()) begin
                n_fail++; $display("FAIL reload_state tick%0d: got %0d/%b expected %0d/%b", k, v, pending, m_count[1], exp_pend());
            end
        end
        n_tests++;
        if (pulses != 4) begin
            n_fail++; $display("FAIL reload_pulses: got %0d expected 4", pulses);
        end
    endtask

    task automatic test_square();
        logic eo, ei, po, pi;
        logic [3:0] seen;
        wr(2, 0, 8'd1);
        wr(2, 1, 8'h05);
        for (int k = 0; k < 4; k++) begin
            do_tick(2, eo, ei, po, pi);
            seen[k] = po;
            n_tests++;
            if (eo !== m_out[2] || po !== m_out[2]) begin
                n_fail++; $display("FAIL square_out tick%0d: got %b/%b expected %b", k, eo, po, m_out[2]);
            end
        end
        n_tests++;
        if (seen !== 4'b0101) begin
            n_fail++; $display("FAIL square_seq: got %b expected 0101 (lsb first 1,0,1,0)", seen);
        end
    endtask

    task automatic test_collisions();
        logic [W-1:0] v;
        // Clear-pending write on the same edge as a square-mode terminal event.
        @(negedge clk);
        tick_in[2] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = {2'd2, 1'b1}; wr_data = 8'h15;
        @(posedge clk); #1;
        model_write(2, 1'b1, 8'h15);
        model_tick(2);
        n_tests++;
        if (pending[2] !== 1'b1 || ch_out[2] !== m_out[2]) begin
            n_fail++; $display("FAIL coll_clr_set: got pend=%b out=%b expected 1/%b", pending[2], ch_out[2], m_out[2]);
        end
        @(negedge clk);
        wr_en = 1'b0; tick_in[2] = 1'b0;
        repeat (3) @(negedge clk);
        // LOAD write on the same edge as a tick on an enabled, counting channel.
        @(negedge clk);
        tick_in[1] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = {2'd1, 1'b0}; wr_data = 8'd5;
        @(negedge clk);
        wr_en = 1'b0;
        model_write(1, 1'b0, 8'd5);
        @(negedge clk);
        tick_in[1] = 1'b0;
        repeat (3) @(negedge clk);
        read_count(1, v);
        n_tests++;
        if (v !== 8'd5 || ch_out[1] !== 1'b0) begin
            n_fail++; $display("FAIL coll_load_tick: got %0d/%b expected 5/0", v, ch_out[1]);
        end
    endtask

    task automatic test_boundaries();
        logic eo, ei, po, pi;
        logic [W-1:0] v;
        wr(3, 0, 8'hAA);
        wr(3, 1, 8'h1F);
        for (int c = 0; c < NCH; c++) begin
            read_count(c, v);
            n_tests++;
            if (v !== m_count[c]) begin
                n_fail++; $display("FAIL bad_ch_count ch%0d: got %0d expected %0d", c, v, m_count[c]);
            end
        end
        n_tests++;
        if (pending !== exp_pend() || ch_out !== exp_out() || irq !== exp_irq()) begin
            n_fail++; $display("FAIL bad_ch_flags: got %b/%b/%b expected %b/%b/%b", pending, ch_out, irq, exp_pend(), exp_out(), exp_irq());
        end
        read_count(3, v);
        n_tests++;
        if (v !== '0) begin
            n_fail++; $display("FAIL rd_bad_ch: got %0d expected 0", v);
        end
        // Zero reload value: the channel stays idle.
        wr(0, 0, 8'd0);
        wr(0, 1, 8'h19);
        for (int k = 0; k < 3; k++) do_tick(0, eo, ei, po, pi);
        read_count(0, v);
        n_tests++;
        if (v !== 8'd0 || pending[0] !== 1'b0 || po !== 1'b0) begin
            n_fail++; $display("FAIL load_zero: got %0d/%b/%b expected 0/0/0", v, pending[0], po);
        end
        // Disabled channel ignores ticks.
        wr(2, 0, 8'd5);
        wr(2, 1, 8'h04);
        for (int k = 0; k < 2; k++) do_tick(2, eo, ei, po, pi);
        read_count(2, v);
        n_tests++;
        if (v !== 8'd5 || ch_out[2] !== 1'b0) begin
            n_fail++; $display("FAIL en_off: got %0d/%b expected 5/0", v, ch_out[2]);
        end
    endtask

    task automatic test_random();
        logic eo, ei, po, pi, ib;
        logic [W-1:0] v;
        int ch, rc;
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: wr(int'($urandom_range(0, 3)), 1'b0, 8'($urandom_range(0, 4)));
                1: wr(int'($urandom_range(0, 3)), 1'b1, 8'($urandom_range(0, 31)));
                default: begin
                    ch = int'($urandom_range(0, NCH - 1));
                    ib = exp_irq();
                    do_tick(ch, eo, ei, po, pi);
                    n_tests++;
                    if (eo !== (m_pulse | m_out[ch]) || po !== m_out[ch] || ei !== ib || pi !== exp_irq()) begin
                        n_fail++;
                        $display("FAIL rand_tick it%0d ch%0d: got %b%b%b%b expected %b%b%b%b", it, ch, eo, po, ei, pi,
                                 m_pulse | m_out[ch], m_out[ch], ib, exp_irq());
                    end
                end
            endcase
            rc = int'($urandom_range(0, NCH - 1));
            read_count(rc, v);
            n_tests++;
            if (v !== m_count[rc] || pending !== exp_pend() || ch_out !== exp_out() || irq !== exp_irq()) begin
                n_fail++;
                $display("FAIL rand_state it%0d ch%0d: got %0d/%b/%b/%b expected %0d/%b/%b/%b", it, rc, v, pending,
                         ch_out, irq, m_count[rc], exp_pend(), exp_out(), exp_irq());
            end
        end
    endtask

    task automatic test_wide();
        logic [15:0] ld[8];
        int          nt[8];
        logic [7:0]  mask;
        logic [15:0] exp_c;
        for (int i = 0; i < 8; i++) begin
            ld[i] = 16'($urandom_range(1, 5));
            nt[i] = 0;
            @(negedge clk);
            w_wr_en = 1'b1; w_wr_addr = {i[2:0], 1'b0}; w_wr_data = ld[i];
            @(negedge clk);
            w_wr_addr = {i[2:0], 1'b1}; w_wr_data = 16'h0003;
            @(negedge clk);
            w_wr_en = 1'b0;
        end
        for (int r = 0; r < 8; r++) begin
            mask = 8'($urandom);
            @(negedge clk);
            w_tick = mask;
            repeat (4) @(negedge clk);
            w_tick = '0;
            repeat (3) @(negedge clk);
            for (int i = 0; i < 8; i++) if (mask[i]) nt[i]++;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            w_rd_ch = i[2:0];
            @(posedge clk); #1;
            exp_c = ld[i] - 16'(nt[i] % int'(ld[i]));
            n_tests++;
            if (w_rd_data !== exp_c || w_pending[i] !== (nt[i] >= int'(ld[i]))) begin
                n_fail++;
                $display("FAIL wide_ch%0d: got %0d/%b expected %0d/%b", i, w_rd_data, w_pending[i], exp_c, nt[i] >= int'(ld[i]));
            end
        end
        n_tests++;
        if (w_ch_out !== 8'h00 || w_irq !== 1'b0) begin
            n_fail++; $display("FAIL wide_out: got %h/%b expected 00/0", w_ch_out, w_irq);
        end
    endtask

    task automatic test_mid_reset();
        logic eo, ei, po, pi;
        logic [W-1:0] v;
        wr(0, 0, 8'd4);
        wr(0, 1, 8'h09);
        do_tick(0, eo, ei, po, pi);
        @(negedge clk);
        RSTN = 1'b0;
        #1;
        n_tests++;
        if ({rd_data, ch_out, pending, irq} !== '0) begin
            n_fail++; $display("FAIL mid_reset_async: got %h expected 0", {rd_data, ch_out, pending, irq});
        end
        repeat (2) @(negedge clk);
        RSTN = 1'b1;
        model_reset();
        do_tick(0, eo, ei, po, pi);
        read_count(0, v);
        n_tests++;
        if (v !== 8'd0 || pending !== 3'b000 || po !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_after: got %0d/%b/%b expected 0/000/0", v, pending, po);
        end
    endtask

    initial begin
        tick_in = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_ch = '0;
        w_tick = '0; w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0; w_rd_ch = '0;
        RSTN = 1'b0;
        model_reset();
        test_reset();
        test_oneshot();
        test_reload();
        test_square();
        test_collisions();
        test_boundaries();
        test_random();
        test_wide();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_array.md
# counter_array

Parametrised N-channel down-counter/timer array, the successor to the fixed three-channel counter peripheral on the MIO bus. Each channel counts on the rising edge of its own slow tick input (a clock-divider tap), supports one-shot, auto-reload and square-wave modes, and raises a maskable interrupt. All logic runs on the single system clock; tick inputs are synchronised internally. The CPU writes it through the bus write strobe, reads it through a registered read port, and the combined interrupt feeds the CPU `INT` input.

## Interface
- `NCH`, 3: number of channels, 1..8.
- `WIDTH`, 32: counter and reload width, 8..32.
- `ADDR_W`, $clog2(NCH)+1: write address width, derived; not overridden.
- `clk`  in  1  system clock.
- `RSTN`  in  1  asynchronous active-low reset.
- `tick_in`  in  NCH  per-channel count ticks, asynchronous to `clk`, each high and low for ≥3 `clk` cycles.
- `wr_en`  in  1  write strobe, one write per asserted cycle.
- `wr_addr`  in  ADDR_W  bit 0: 0 = LOAD, 1 = CTRL; bits [ADDR_W-1:1]: channel index.
- `wr_data`  in  WIDTH  write data.
- `rd_ch`  in  ADDR_W-1  channel whose count is read.
- `rd_data`  out  WIDTH  count of `rd_ch`, registered.
- `ch_out`  out  NCH  per-channel terminal output.
- `pending`  out  NCH  per-channel interrupt-pending flags.
- `irq`  out  1  OR of `pending & irq_en`, registered.

## Operation
- Per-channel state: `load` (WIDTH), `count` (WIDTH), CTRL {`en`, `mode`[1:0], `irq_en`}, `out`, `pend`.
- CTRL write bits: [0] `en`, [2:1] `mode` (00 one-shot, 01 auto-reload, 10 square, 11 one-shot), [3] `irq_en`, [4] `clr_pend` (write-1-to-clear, not stored).
- LOAD write: `load` ← `wr_data`, `count` ← `wr_data`, `out` ← 0. `pend` unchanged.
- Writes with channel index ≥ NCH are ignored.
- Tick: `tick_in[i]` passes through a 2-FF synchroniser; a rising edge on the synchronised signal produces a one-cycle tick event.
- On a tick event with `en`=1:
  - `count` > 1: `count` − 1.
  - `count` = 1 (terminal): `pend` ← 1, plus:
    - one-shot: `count` ← 0, `out` ← 1 (level, held until next LOAD write).
    - auto-reload: `count` ← `load`, `out` pulses high for exactly one cycle.
    - square: `count` ← `load`, `out` toggles.
  - `count` = 0: no change, no event; a channel with `load` = 0 is idle.
- A tick event with `en`=0 is dropped, not queued.
- A LOAD write and a tick event in the same cycle on the same channel: the write wins and the tick is dropped.
- `clr_pend` and a terminal event in the same cycle: set wins, `pend` stays 1.
- Changing `mode` mid-count takes effect at the next terminal event; `out` keeps its value.
- Every register and output resets to 0: `load`, `count`, CTRL, `out`, `pend`, `rd_data`, `irq`, and the synchroniser/edge flops. Asserting `RSTN` mid-count aborts the count immediately.

## Timing
- Latency from a `tick_in` rising edge to the `count` update: 3 `clk` edges (2 synchroniser stages + edge register).
- `ch_out` and `pending` update in the same cycle as `count`; `irq` follows one cycle later.
- A write is visible in channel state on the `clk` edge that samples `wr_en`.
- `rd_data` returns the count one cycle after `rd_ch` is presented, showing the value held before that edge.
- Maximum tick rate: one event per 6 `clk` cycles per channel.
- No backpressure; writes always complete in one cycle.

## Structure
- Package `counter_array_pkg`:
  - mode encodings: `MODE_ONESHOT`, `MODE_RELOAD`, `MODE_SQUARE`;
  - CTRL bit positions: `CTRL_EN`, `CTRL_MODE_LSB`, `CTRL_IRQEN`, `CTRL_CLRPEND`.
- Sub-module `counter_chan`, instantiated NCH times in a generate loop. It contains the synchroniser, edge detector, count/reload logic, CTRL, `out` and `pend` for one channel, with WIDTH as its parameter.
- The top level holds write-address decode, the `rd_data` mux register and the `irq` reduction.

## Test plan
- Reset: hold `RSTN`=0 with random inputs → all outputs 0; release → still 0 until the first write.
- One-shot, ch0: LOAD=3, CTRL=0x01, 3 ticks → count 2,1,0; `ch_out[0]` rises 3 clk after the 3rd tick edge and stays high; further ticks leave count at 0.
- Auto-reload, ch1, WIDTH=8: LOAD=2, CTRL=0x0B, 6 ticks → 3 one-cycle `ch_out[1]` pulses; `irq` high 1 cycle after the first; CTRL write 0x1B → `pend[1]` clears and `irq` drops, then re-sets at the next terminal.
- Square, ch2: LOAD=1, CTRL=0x05, 4 ticks → `ch_out[2]` toggles 1,0,1,0.
- Collisions: `clr_pend` in the same cycle as a terminal event → `pend` stays 1; LOAD write in the same cycle as a tick → count equals the written value.
- Boundaries: write to channel index NCH → no state change; LOAD=0 with ticks → no events; `en`=0 ticks → count frozen; NCH=8, WIDTH=16 build → wr_addr 4 bits, all channels independent.
